// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin arbiter.
// Holds the arbiter state enum, the index-width helper and the
// one-hot to binary encoder used by the priority picker.
package rr_arb_pkg;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

    // Index width for n requesters (ceil(log2(n)), minimum 1 bit).
    function automatic int rr_idx_w(input int n);
        int w;
        w = 1;
        for (int i = 1; i < 31; i++) begin
            if ((1 << i) < n) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

    // Binary index of a one-hot vector (up to 64 requesters). OR-encoding
    // keeps this a flat gate tree; the result is only defined for one-hot input.
    function automatic int onehot_to_idx(input logic [63:0] vec);
        int idx;
        idx = 0;
        for (int i = 0; i < 64; i++) begin
            if (vec[i]) begin
                idx = idx | i;
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter_enc_pick.sv
// Combinational round-robin picker: scans {req,req} from bit ptr upward,
// takes the lowest set bit and folds it back modulo N_REQ.
module rr_priority_pick
    import rr_arb_pkg::*;
#(
    parameter int N_REQ = 8,
    parameter int IDX_W = rr_idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [N_REQ-1:0] winner_onehot,
    output logic [IDX_W-1:0] winner_idx
);

    logic [2*N_REQ-1:0] masked;
    logic               hit;

    // Masked double-width scan; the first set bit at or above ptr wins.
    always_comb begin
        found         = |req;
        masked        = '0;
        hit           = 1'b0;
        winner_onehot = '0;
        for (int i = 0; i < 2*N_REQ; i++) begin
            masked[i] = req[i % N_REQ] && (i >= int'(ptr));
        end
        for (int i = 0; i < 2*N_REQ; i++) begin
            if (masked[i] && !hit) begin
                hit                      = 1'b1;
                winner_onehot[i % N_REQ] = 1'b1;
            end
        end
        winner_idx = IDX_W'(onehot_to_idx(64'(winner_onehot)));
    end

endmodule

// File: rtl/rr_arbiter_enc.sv
// Round-robin arbiter with one-hot and binary grant outputs.
// The owner keeps the grant until it pulses done or drops its request;
// on release the pointer moves past the owner and the next winner is
// loaded on the same edge. Optional forced release after MAX_HOLD cycles
// is built only when RR_ARB_TIMEOUT_EN is defined; otherwise timeout is 0.
module rr_arbiter_enc
    import rr_arb_pkg::*;
#(
    parameter int N_REQ    = 8,
    parameter int IDX_W    = rr_idx_w(N_REQ),
    parameter int MAX_HOLD = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [N_REQ-1:0] grant_onehot,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_valid,
    output logic             timeout
);

    if (N_REQ < 2 || N_REQ > 64) begin : g_bad_n_req
        $error("rr_arbiter_enc: N_REQ must be in 2..64");
    end
    if (IDX_W != rr_idx_w(N_REQ)) begin : g_bad_idx_w
        $error("rr_arbiter_enc: IDX_W is derived from N_REQ and must not be overridden");
    end
    if (MAX_HOLD < 2) begin : g_bad_max_hold
        $error("rr_arbiter_enc: MAX_HOLD must be at least 2");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] ptr_after_owner;
    logic [IDX_W-1:0] pick_ptr;
    logic             found;
    logic [N_REQ-1:0] win_onehot;
    logic [IDX_W-1:0] win_idx;
    logic             rel_normal;
    logic             rel_force;
    logic             rel_now;
    logic             grant_load;

    // Pointer value the owner hands over on release (owner+1 wrapping).
    always_comb begin
        if (grant_idx == IDX_W'(N_REQ - 1)) begin
            ptr_after_owner = '0;
        end else begin
            ptr_after_owner = grant_idx + 1'b1;
        end
    end

    assign rel_normal = done | ~req[grant_idx];
    assign rel_now    = (state == ARB_GRANT) & (rel_normal | rel_force);
    // Re-arbitrate with the post-release pointer so there is no idle bubble.
    assign pick_ptr   = rel_now ? ptr_after_owner : ptr;
    assign grant_load = found & ((state == ARB_IDLE) | rel_now);

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req           (req),
        .ptr           (pick_ptr),
        .found         (found),
        .winner_onehot (win_onehot),
        .winner_idx    (win_idx)
    );

    // Arbiter FSM: load a winner from IDLE or on release, else go idle on release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ARB_IDLE;
            ptr          <= '0;
            grant_onehot <= '0;
            grant_idx    <= '0;
            grant_valid  <= 1'b0;
        end else begin
            if (rel_now) begin
                ptr <= ptr_after_owner;
            end
            if (grant_load) begin
                state        <= ARB_GRANT;
                grant_onehot <= win_onehot;
                grant_idx    <= win_idx;
                grant_valid  <= 1'b1;
            end else if (rel_now) begin
                state        <= ARB_IDLE;
                grant_onehot <= '0;
                grant_idx    <= '0;
                grant_valid  <= 1'b0;
            end
        end
    end

`ifdef RR_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_HOLD) + 1;

    logic [CNT_W-1:0] hold_cnt;

    assign rel_force = (hold_cnt == CNT_W'(MAX_HOLD - 1));

    // Hold counter restarts on each new grant; timeout flags a forced release
    // that was not also a normal release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= rel_now & rel_force & ~rel_normal;
            if (grant_load) begin
                hold_cnt <= '0;
            end else if (state == ARB_GRANT) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    assign rel_force = 1'b0;
    assign timeout   = 1'b0;
`endif

endmodule

// File: tb/tb_rr_arbiter_enc.sv
// Directed bench for rr_arbiter_enc (N_REQ=4, MAX_HOLD=16) with a
// behavioural reference model checked every cycle.
module tb_rr_arbiter_enc;

    localparam int N        = 4;
    localparam int MAX_HOLD = 16;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] req;
    logic         done;
    logic [N-1:0] grant_onehot;
    logic [1:0]   grant_idx;
    logic         grant_valid;
    logic         timeout;

    int n_vec;
    int n_err;
    bit run_cmp;

    rr_arbiter_enc #(
        .N_REQ    (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req),
        .done         (done),
        .grant_onehot (grant_onehot),
        .grant_idx    (grant_idx),
        .grant_valid  (grant_valid),
        .timeout      (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_owner;   // -1 = nobody
    int m_ptr;
    int m_held;    // cycles the current owner has held the grant
    bit m_to;

    function automatic int pick(input logic [N-1:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge rst_n) begin : model
        bit rel_n;
        bit forced;
        if (!rst_n) begin
            m_owner = -1;
            m_ptr   = 0;
            m_held  = 0;
            m_to    = 0;
        end else begin
            m_to = 0;
            if (m_owner < 0) begin
                m_owner = pick(req, m_ptr);
                m_held  = 1;
            end else begin
                rel_n  = done || !req[m_owner];
                forced = 0;
`ifdef RR_ARB_TIMEOUT_EN
                forced = (m_held == MAX_HOLD);
`endif
                if (rel_n || forced) begin
                    m_ptr   = (m_owner + 1) % N;
                    m_owner = pick(req, m_ptr);
                    m_held  = 1;
                    m_to    = forced && !rel_n;
                end else begin
                    m_held++;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (run_cmp) begin
            chk("mdl_valid", 32'(grant_valid), 32'(m_owner >= 0));
            chk("mdl_idx", 32'(grant_idx), (m_owner >= 0) ? 32'(m_owner) : 32'd0);
            chk("mdl_onehot", 32'(grant_onehot), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("mdl_timeout", 32'(timeout), 32'(m_to));
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        n_vec   = 0;
        n_err   = 0;
        run_cmp = 0;
        rst_n   = 1'b0;
        req     = 4'b1111;
        done    = 1'b0;
        tick();
        tick();
        run_cmp = 1;
        chk("rst_onehot", 32'(grant_onehot), 32'd0);
        chk("rst_idx", 32'(grant_idx), 32'd0);
        chk("rst_valid", 32'(grant_valid), 32'd0);
        chk("rst_timeout", 32'(timeout), 32'd0);
        rst_n = 1'b1;
        tick();
        chk("first_grant_idx", 32'(grant_idx), 32'd0);
        chk("first_grant_valid", 32'(grant_valid), 32'd1);

        // fairness: done once per grant, req all high
        for (int k = 1; k <= 4; k++) begin
            done = 1'b1;
            tick();
            done = 1'b0;
            chk("fair_idx", 32'(grant_idx), 32'(k % 4));
            chk("fair_valid", 32'(grant_valid), 32'd1);
            tick();
            chk("fair_hold_idx", 32'(grant_idx), 32'(k % 4));
        end
        req = 4'b0000;
        tick();
        chk("fair_idle", 32'(grant_valid), 32'd0);

        // single request
        req = 4'b0100;
        tick();
        chk("single_valid", 32'(grant_valid), 32'd1);
        chk("single_onehot", 32'(grant_onehot), 32'b0100);
        chk("single_idx", 32'(grant_idx), 32'd2);
        req = 4'b0000;
        tick();
        chk("single_drop_valid", 32'(grant_valid), 32'd0);
        chk("single_drop_onehot", 32'(grant_onehot), 32'd0);
        chk("single_drop_idx", 32'(grant_idx), 32'd0);

        // owner drop and non-owner changes ignored
        req = 4'b0010;
        tick();
        chk("own_idx1", 32'(grant_idx), 32'd1);
        req = 4'b1010;
        tick();
        tick();
        chk("own_ignore_idx", 32'(grant_idx), 32'd1);
        req = 4'b1000;
        tick();
        chk("own_drop_idx", 32'(grant_idx), 32'd3);
        req = 4'b0000;
        tick();

`ifdef RR_ARB_TIMEOUT_EN
        req = 4'b0011;
        tick();
        for (int c = 2; c <= MAX_HOLD; c++) begin
            tick();
            chk("to_hold_idx", 32'(grant_idx), 32'd0);
            chk("to_hold_pulse", 32'(timeout), 32'd0);
        end
        tick();
        chk("to_next_idx", 32'(grant_idx), 32'd1);
        chk("to_pulse", 32'(timeout), 32'd1);
        req = 4'b0001;
        tick();
        chk("to_pulse_width", 32'(timeout), 32'd0);
        chk("to_back0_idx", 32'(grant_idx), 32'd0);
        for (int c = 2; c <= MAX_HOLD; c++) tick();
        tick();
        chk("to_self_idx", 32'(grant_idx), 32'd0);
        chk("to_self_pulse", 32'(timeout), 32'd1);
        for (int c = 2; c <= MAX_HOLD; c++) tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("to_done_idx", 32'(grant_idx), 32'd0);
        chk("to_done_pulse", 32'(timeout), 32'd0);
        req = 4'b0000;
        tick();
`else
        req = 4'b0011;
        tick();
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("long_hold_idx", 32'(grant_idx), 32'd0);
            chk("long_hold_timeout", 32'(timeout), 32'd0);
        end
        req = 4'b0000;
        tick();
`endif

        // done while idle is ignored
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("idle_done_valid", 32'(grant_valid), 32'd0);

        // leave ptr at 3, then re-grant owner 2 and reset mid-cycle
        req = 4'b0100;
        tick();
        req = 4'b0000;
        tick();
        req = 4'b0100;
        tick();
        chk("pre_rst_idx", 32'(grant_idx), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", 32'(grant_valid), 32'd0);
        chk("async_rst_onehot", 32'(grant_onehot), 32'd0);
        chk("async_rst_idx", 32'(grant_idx), 32'd0);
        req = 4'b1100;
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idx", 32'(grant_idx), 32'd2);
        chk("post_rst_valid", 32'(grant_valid), 32'd1);
        req = 4'b0000;
        tick();
        tick();

        run_cmp = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
